// File: rtl/bit_packer_pkg.sv
// Shared compression constants: code-word limits, output word geometry and
// the packer state encoding. Also imported by the length generator.
package bit_packer_pkg;

    localparam int MAX_CODE_LEN = 34;   // longest compressed code word
    localparam int LENGTH_W     = 6;    // width of a code-length field
    localparam int OUT_WORD_W   = 32;   // packed output word width
    localparam int COUNT_W      = 7;    // fill count, covers 0..CODE_W+OUT_W
    localparam int LAST_BITS_W  = 6;    // valid-bit count of the final word, 0..32

    // Packer state encoding (legacy-compatible constants).
    localparam logic [0:0] ST_PACK  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/bit_packer_if.sv
// Code-word input and packed-word output handshakes of the bit packer.
interface bit_packer_if import bit_packer_pkg::*; #(
    parameter int CODE_W = MAX_CODE_LEN,
    parameter int LENGTH = LENGTH_W,
    parameter int OUT_W  = OUT_WORD_W
);
    logic                   i_valid;
    logic                   o_ready;
    logic [CODE_W-1:0]      i_data;
    logic [LENGTH-1:0]      i_length;
    logic                   i_last;
    logic                   o_valid;
    logic                   i_ready;
    logic [OUT_W-1:0]       o_data;
    logic                   o_last;
    logic [LAST_BITS_W-1:0] o_last_bits;

    // Packer side.
    modport slave (
        input  i_valid, i_data, i_length, i_last, i_ready,
        output o_ready, o_valid, o_data, o_last, o_last_bits
    );

    // Source/sink side (code-word producer and packed-word consumer).
    modport master (
        output i_valid, i_data, i_length, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_last_bits
    );
endinterface

// File: rtl/bit_aligner.sv
// Combinational shifter: masks a right-justified code word to its length and
// places it MSB-first directly below the current fill of the packing buffer.
module bit_aligner import bit_packer_pkg::*; #(
    parameter int CODE_W = MAX_CODE_LEN,
    parameter int LENGTH = LENGTH_W,
    parameter int OUT_W  = OUT_WORD_W
) (
    input  logic [CODE_W-1:0]        i_data,
    input  logic [LENGTH-1:0]        i_length,   // already saturated to CODE_W
    input  logic [COUNT_W-1:0]       i_fill,
    output logic [CODE_W+OUT_W-1:0]  o_bits
);
    localparam int BUF_W = CODE_W + OUT_W;
    localparam int LW1   = LENGTH + 1;

    logic [CODE_W-1:0] w_masked;
    logic [LENGTH:0]   w_lead;
    logic [BUF_W-1:0]  w_top;

    // Drop bits above the code length; a full-width length shifts every one out.
    assign w_masked = i_data & ~({CODE_W{1'b1}} << i_length);
    // Zero bits above the code word once it sits at the top of the buffer.
    assign w_lead   = LW1'(CODE_W) - {1'b0, i_length};
    assign w_top    = {w_masked, {OUT_W{1'b0}}} << w_lead;
    assign o_bits   = w_top >> i_fill;
endmodule

// File: rtl/bit_packer.sv
// Packs variable-length code words MSB-first into fixed OUT_W-bit words,
// flushing a zero-padded final word (with its valid-bit count) at stream end.
module bit_packer import bit_packer_pkg::*; #(
    parameter int CODE_W = MAX_CODE_LEN,
    parameter int LENGTH = LENGTH_W,
    parameter int OUT_W  = OUT_WORD_W
) (
    input  logic        i_clk,
    input  logic        i_reset,
    bit_packer_if.slave bus
);
    localparam int BUF_W = CODE_W + OUT_W;

    logic [BUF_W-1:0]   r_buf;
    logic [COUNT_W-1:0] r_count;
    logic [0:0]         r_state;

    logic [LENGTH-1:0]  w_len_sat;
    logic [BUF_W-1:0]   w_aligned;
    logic               w_accept;
    logic               w_emit;
    logic               w_final;

    assign w_len_sat = (bus.i_length > LENGTH'(CODE_W)) ? LENGTH'(CODE_W) : bus.i_length;

    bit_aligner #(
        .CODE_W   (CODE_W),
        .LENGTH   (LENGTH),
        .OUT_W    (OUT_W)
    ) u_aligner (
        .i_data   (bus.i_data),
        .i_length (w_len_sat),
        .i_fill   (r_count),
        .o_bits   (w_aligned)
    );

    // Input and output never handshake together: o_ready needs count<OUT_W,
    // which in PACK also means o_valid is low.
    assign bus.o_ready = !i_reset && (r_state == ST_PACK) && (r_count < COUNT_W'(OUT_W));
    assign w_accept    = bus.i_valid && bus.o_ready;

    // Outputs come straight from state registers, so they hold under backpressure.
    assign w_final         = (r_state == ST_FLUSH) && (r_count <= COUNT_W'(OUT_W));
    assign bus.o_valid     = (r_state == ST_FLUSH) || (r_count >= COUNT_W'(OUT_W));
    assign bus.o_data      = r_buf[BUF_W-1 -: OUT_W];
    assign bus.o_last      = w_final;
    assign bus.o_last_bits = w_final ? LAST_BITS_W'(r_count) : '0;
    assign w_emit          = bus.o_valid && bus.i_ready;

    // Buffer, fill count and state: append on accept, shift out on emit.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (i_reset) begin
            r_buf   <= '0;
            r_count <= '0;
            r_state <= ST_PACK;
        end else if (w_accept) begin
            // Bits below the fill are always zero, so OR-ing appends in place.
            r_buf   <= r_buf | w_aligned;
            r_count <= r_count + COUNT_W'(w_len_sat);
            if (bus.i_last)
                r_state <= ST_FLUSH;
        end else if (w_emit) begin
            if (w_final) begin
                r_buf   <= '0;
                r_count <= '0;
                r_state <= ST_PACK;
            end else begin
                r_buf   <= r_buf << OUT_W;
                r_count <= r_count - COUNT_W'(OUT_W);
            end
        end
    end
endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: a bit-level reference model feeds a
// scoreboard of expected output words, plus directed corner sequences.
module tb_bit_packer;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [5:0]  bits;
    } out_t;

    typedef struct {
        logic [33:0] d;
        logic [5:0]  len;
        logic [31:0] exp_data;
        logic [5:0]  exp_bits;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    out_t exp_q[$];
    bit   mq[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    bit_packer_if bus ();

    bit_packer dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change only just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic last, input int n);
        out_t e;
        e.data = '0;
        for (int i = 0; i < n; i++) e.data[31-i] = mq.pop_front();
        e.last = last;
        e.bits = last ? 6'(n) : 6'd0;
        exp_q.push_back(e);
    endtask

    // Reference model: bit FIFO, words popped eagerly except the stream's last.
    task automatic model_push(input logic [33:0] d, input logic [5:0] len, input logic last);
        int l;
        l = (len > 6'd34) ? 34 : int'(len);
        for (int i = l - 1; i >= 0; i--) mq.push_back(d[i]);
        if (!last) begin
            while (mq.size() >= 32) push_word(1'b0, 32);
        end else begin
            while (mq.size() > 32) push_word(1'b0, 32);
            push_word(1'b1, mq.size());
        end
    endtask

    task automatic send(input logic [33:0] d, input logic [5:0] len, input logic last);
        int   n;
        logic ok;
        n = 0;
        bus.i_valid  = 1'b1;
        bus.i_data   = d;
        bus.i_length = len;
        bus.i_last   = last;
        do begin
            @(negedge clk);
            ok = bus.o_ready;
            n++;
        end while (!ok && n < 300);
        check("send_accept_timeout", ok, 1);
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic model_send(input logic [33:0] d, input logic [5:0] len, input logic last);
        model_push(d, len, last);
        send(d, len, last);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        bus.i_valid = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("ready_in_reset", bus.o_ready, 0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_last", bus.o_last, 0);
        check("rst_o_last_bits", bus.o_last_bits, 0);
        check("rst_o_data", bus.o_data, 0);
        check("rst_o_ready", bus.o_ready, 1);
        tick();
    endtask

    // Scoreboard: compare every output handshake with the oldest expectation.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {31'd0, bus.o_last, bus.o_data}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.o_data, e.data);
                    check("out_last", bus.o_last, e.last);
                    check("out_last_bits", bus.o_last_bits, e.bits);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{34'h0_0000_0ABC, 6'd12, 32'hABC0_0000, 6'd12};
        vecs[1] = '{34'h3_FFFF_FFFF, 6'd0,  32'h0000_0000, 6'd0};
        vecs[2] = '{34'h0_1234_5678, 6'd32, 32'h1234_5678, 6'd32};
        vecs[3] = '{34'h0_0000_0001, 6'd1,  32'h8000_0000, 6'd1};
        vecs[4] = '{34'h3_FFFF_FFFF, 6'd5,  32'hF800_0000, 6'd5};
        vecs[5] = '{34'h3_0000_0001, 6'd31, 32'h0000_0002, 6'd31};

        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_length = '0;
        bus.i_last   = 1'b0;
        bus.i_ready  = 1'b1;
        do_reset();

        // Single-word streams, each closed by i_last.
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{vecs[i].exp_data, 1'b1, vecs[i].exp_bits});
            send(vecs[i].d, vecs[i].len, 1'b1);
            wait_drain();
        end

        // 16 two-bit codes fill one word; then hold it under backpressure.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 16; i++) model_send(34'h3_FFFF_FFFE, 6'd2, 1'b0);
        @(negedge clk);
        check("pack_o_valid", bus.o_valid, 1);
        check("pack_o_data", bus.o_data, 32'hAAAA_AAAA);
        tick();
        bus.i_valid  = 1'b1;
        bus.i_data   = 34'h0_0000_000F;
        bus.i_length = 6'd4;
        bus.i_last   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_o_valid", bus.o_valid, 1);
            check("bp_o_data", bus.o_data, 32'hAAAA_AAAA);
            check("bp_o_ready", bus.o_ready, 0);
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        model_send(34'h0, 6'd0, 1'b1);
        wait_drain();

        // Straddle: a 34-bit code overflows one word by two bits.
        bus.i_ready = 1'b0;
        model_send(34'h3_FFFF_FFFF, 6'd34, 1'b0);
        @(negedge clk);
        check("straddle_o_ready", bus.o_ready, 0);
        check("straddle_o_data", bus.o_data, 32'hFFFF_FFFF);
        tick();
        bus.i_ready = 1'b1;
        tick();
        @(negedge clk);
        check("straddle_ready_after", bus.o_ready, 1);
        check("straddle_valid_after", bus.o_valid, 0);
        tick();
        model_send(34'h0, 6'd0, 1'b1);
        wait_drain();

        // Exact multiples of the word width at flush.
        model_send(34'h0_DEAD_BEEF, 6'd32, 1'b0);
        model_send(34'h0_CAFE_F00D, 6'd32, 1'b1);
        wait_drain();
        model_send(34'h0_5555_5555, 6'd31, 1'b0);
        model_send(34'h1_3333_3333, 6'd33, 1'b1);
        wait_drain();

        // Oversized length saturates to 34.
        model_send(34'h0_0000_0003, 6'd40, 1'b1);
        wait_drain();

        // Random streams.
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 6; w++)
                model_send(34'({$urandom(), $urandom()}), 6'($urandom_range(0, 40)), w == 5);
            wait_drain();
        end

        // Reset mid-stream with a full word pending: nothing stale may follow.
        bus.i_ready = 1'b0;
        model_send(34'h3_FFFF_FFFF, 6'd34, 1'b0);
        exp_q.delete();
        mq.delete();
        do_reset();
        bus.i_ready = 1'b1;
        model_send(34'h0, 6'd0, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 SHALL provide parameter CODE_W, default 34: width of i_data, equal to the longest compressed code word (xxxx).
REQ-002 SHALL provide parameter LENGTH, default 6: width of i_length.
REQ-003 SHALL provide parameter OUT_W, default 32: width of each packed output word.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_valid, input, 1: a code word is offered.
REQ-007 SHALL have port o_ready, output, 1: the packer accepts the offered code word this cycle.
REQ-008 SHALL have port i_data, input, CODE_W: code word, right-justified in i_data[i_length-1:0].
REQ-009 SHALL have port i_length, input, LENGTH: code word length in bits, 0..34, produced by the length generator.
REQ-010 SHALL have port i_last, input, 1: the offered word ends the stream; qualified by i_valid.
REQ-011 SHALL have port o_valid, output, 1: o_data holds a packed word.
REQ-012 SHALL have port i_ready, input, 1: downstream accepts o_data.
REQ-013 SHALL have port o_data, output, OUT_W: packed word, first-arrived bit in o_data[OUT_W-1].
REQ-014 SHALL have port o_last, output, 1: o_data is the final word of the stream.
REQ-015 SHALL have port o_last_bits, output, 6: number of valid MSB bits in the final word, 0..32; zero when o_last=0.

Function
REQ-016 SHALL keep an accumulation buffer of CODE_W+OUT_W bits and a 7-bit fill count, MSB-aligned.
REQ-017 SHALL accept a word on the cycle i_valid and o_ready are both high; bits of i_data above i_length are ignored.
REQ-018 SHALL append accepted bits directly after the current fill, MSB-first, and add i_length to the count.
REQ-019 SHALL saturate i_length values above 34 to 34.
REQ-020 SHALL accept length 0 as a no-op for data but honour i_last.
REQ-021 SHALL drive o_ready=1 only in state PACK with count<OUT_W.
REQ-022 SHALL drive o_valid=1 when count>=OUT_W, or in state FLUSH; o_data=buffer top OUT_W bits, registered.
REQ-023 SHALL shift the buffer left OUT_W and subtract OUT_W from the count when o_valid and i_ready are both high; saturate at zero in FLUSH.
REQ-024 SHALL assert o_valid on the cycle after the accepting edge that raises count to >=OUT_W; latency in to out is 1 cycle.
REQ-025 SHALL hold o_data, o_valid, o_last and o_last_bits stable while o_valid=1 and i_ready=0.
REQ-026 SHALL have FSM states PACK and FLUSH.
REQ-027 SHALL transition PACK->FLUSH on acceptance of a word with i_last=1.
REQ-028 SHALL drive o_ready=0 in FLUSH.
REQ-029 SHALL emit remaining full words in FLUSH, then one final word zero-padded in its LSBs.
REQ-030 SHALL assert o_last with o_last_bits=count (1..32) on the final word.
REQ-031 SHALL, when the count is an exact multiple of OUT_W at flush, mark the last full word with o_last=1 and o_last_bits=32.
REQ-032 SHALL, when the stream is empty (count=0 at flush), emit one zero word with o_last=1 and o_last_bits=0.
REQ-033 SHALL transition FLUSH->PACK on the handshake of the o_last word, with count=0 and the buffer cleared.

Reset
REQ-034 SHALL, while i_reset=1, clear the buffer, set count=0, state=PACK, o_valid=0, o_last=0, o_last_bits=0, o_data=0; o_ready=0 during reset and 1 on the first cycle after it.
REQ-035 SHALL abandon any partial or flushing stream on reset mid-operation; no o_last is emitted for it.

Structure
REQ-036 SHALL place MAX_CODE_LEN=34, LENGTH=6, OUT_W=32 and the packer state enum in the shared compression package, also used by length_generator.
REQ-037 SHALL use one sub-module, bit_aligner: a combinational shifter that positions masked i_data at the current fill offset.

Verification
REQ-038 SHALL cover reset: i_reset=1 for 2 cycles mid-stream -> o_valid=0, o_last=0, o_ready=1 on the next cycle, no stale data emitted.
REQ-039 SHALL cover packing: 16 words, length 2, data 2'b10 -> one cycle later o_valid=1, o_data=32'hAAAA_AAAA.
REQ-040 SHALL cover straddle: length 34, data 34'h3_FFFF_FFFF -> o_ready=0, o_data=32'hFFFF_FFFF; after handshake count=2, o_ready=1.
REQ-041 SHALL cover backpressure: i_ready=0 for 5 cycles with o_valid=1 -> o_data stable, o_ready=0, no input accepted.
REQ-042 SHALL cover flush: length 12, data 12'hABC, i_last=1 -> o_data=32'hABC0_0000, o_last=1, o_last_bits=12; then o_ready=1.
REQ-043 SHALL cover the empty stream: length 0 with i_last=1 -> o_data=0, o_last=1, o_last_bits=0.
